debounce_bank: RTL and testbench

//   Multi-channel switch debouncer with input synchroniser, per-channel stability counters,
//   one-cycle rise/fall strobes and long-press detection.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 124 ++++++++++++
 rtl/debounce_bank.sv | 59 +++++
 tb/tb_debounce_bank.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for tick-paced debounce logic.
package debounce_pkg;

    localparam int DEBOUNCE_TICK_MS   = 32'd1;
    localparam int DEFAULT_MAX_COUNT  = 32'd16;
    localparam int DEFAULT_LONG_COUNT = 32'd1000;

    // Counter width for a window of n ticks, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 32'd1) begin
            return 32'd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability window, edge strobes and long-press timer.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   MAX_COUNT   = DEFAULT_MAX_COUNT,
    parameter int   LONG_COUNT  = DEFAULT_LONG_COUNT,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic held,
    output logic long_press,
    output logic change_next
);

    localparam int              CW       = cnt_width(MAX_COUNT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next_s;
    logic                   level_r;
    logic                   level_next_s;
    logic                   rise_r;
    logic                   fall_r;
    logic                   rise_next_s;
    logic                   fall_next_s;
    logic                   sample_s;

    assign sample_s = sync_r[SYNC_STAGES-1];

    // Stability window: any agreeing tick restarts it, the last disagreeing tick commits.
    always_comb begin
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;
        if (tick) begin
            if (sample_s != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = '0;
                    level_next_s = sample_s;
                    rise_next_s  = sample_s;
                    fall_next_s  = ~sample_s;
                end else begin
                    cnt_next_s = cnt_r + CW'(1'b1);
                end
            end else begin
                cnt_next_s = '0;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Synchroniser runs every clock; window, level and strobes update from next-state.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_r   <= '0;
            level_r <= INIT_LEVEL;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], raw};
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    generate
        if (LONG_COUNT > 0) begin : g_long
            localparam int            LW     = $clog2(LONG_COUNT + 1);
            localparam logic [LW-1:0] LC_MAX = LW'(LONG_COUNT);

            logic [LW-1:0] lc_r;
            logic          held_r;
            logic          lp_r;

            // held drops on the same tick the level falls, so it keys off next-state.
            always_ff @(posedge clock) begin
                if (reset) begin
                    lc_r   <= '0;
                    held_r <= 1'b0;
                    lp_r   <= 1'b0;
                end else begin
                    lp_r <= 1'b0;
                    if (tick) begin
                        if (!level_next_s) begin
                            lc_r   <= '0;
                            held_r <= 1'b0;
                        end else if (level_r && (lc_r != LC_MAX)) begin
                            lc_r <= lc_r + LW'(1'b1);
                            if (lc_r == (LC_MAX - LW'(1'b1))) begin
                                held_r <= 1'b1;
                                lp_r   <= 1'b1;
                            end
                        end
                    end
                end
            end

            assign held       = held_r;
            assign long_press = lp_r;
        end else begin : g_no_long
            assign held       = 1'b0;
            assign long_press = 1'b0;
        end
    endgenerate

    assign level       = level_r;
    assign rise        = rise_r;
    assign fall        = fall_r;
    assign change_next = rise_next_s | fall_next_s;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced switch channels paced by a shared sample tick.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   CHANNELS    = 8,
    parameter int   MAX_COUNT   = DEFAULT_MAX_COUNT,
    parameter int   LONG_COUNT  = DEFAULT_LONG_COUNT,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_change
);

    logic [CHANNELS-1:0] change_next_s;
    logic                any_change_r;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            debounce_channel #(
                .MAX_COUNT  (MAX_COUNT),
                .LONG_COUNT (LONG_COUNT),
                .SYNC_STAGES(SYNC_STAGES),
                .INIT_LEVEL (INIT_LEVEL)
            ) u_channel (
                .clock      (clock),
                .reset      (reset),
                .tick       (tick),
                .raw        (in[i]),
                .level      (out[i]),
                .rise       (rise[i]),
                .fall       (fall[i]),
                .held       (held[i]),
                .long_press (long_press[i]),
                .change_next(change_next_s[i])
            );
        end
    endgenerate

    // Registered from next-state so it lines up with the rise/fall strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            any_change_r <= 1'b0;
        end else begin
            any_change_r <= |change_next_s;
        end
    end

    assign any_change = any_change_r;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboarded bench for debounce_bank: slow-tick instance plus a tick-tied-high instance.
module tb_debounce_bank;

    localparam int A_MAX  = 16;
    localparam int A_LONG = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] in_a, out_a, rise_a, fall_a, held_a, lp_a;
    logic       any_a;
    logic [7:0] in_b, out_b, rise_b, fall_b, held_b, lp_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];

    logic [7:0] m_s1, m_s2, m_out, m_rise, m_fall, m_held, m_lp;
    logic       m_any;
    int         m_cnt[8];
    int         m_lc[8];

    always #5 clock = ~clock;

    debounce_bank #(.CHANNELS(8), .MAX_COUNT(A_MAX), .LONG_COUNT(A_LONG),
                    .SYNC_STAGES(2), .INIT_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset(reset), .tick(tick), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .held(held_a),
        .long_press(lp_a), .any_change(any_a)
    );

    debounce_bank #(.CHANNELS(8), .MAX_COUNT(4), .LONG_COUNT(0),
                    .SYNC_STAGES(2), .INIT_LEVEL(1'b0)) dut_b (
        .clock(clock), .reset(reset), .tick(1'b1), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .held(held_b),
        .long_press(lp_b), .any_change(any_b)
    );

    // Spec-level model of instance A: counts consecutive disagreeing ticks per channel.
    task automatic model_edge(input logic r, input logic t, input logic [7:0] din);
        logic [7:0] nout;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_held = '0; m_lp = '0; m_any = 1'b0;
            for (int c = 0; c < 8; c++) begin
                m_cnt[c] = 0;
                m_lc[c]  = 0;
            end
        end else begin
            nout = m_out; m_rise = '0; m_fall = '0; m_lp = '0;
            if (t) begin
                for (int c = 0; c < 8; c++) begin
                    if (m_s2[c] != m_out[c]) begin
                        m_cnt[c] = m_cnt[c] + 1;
                        if (m_cnt[c] == A_MAX) begin
                            nout[c]  = m_s2[c];
                            m_cnt[c] = 0;
                            if (m_s2[c]) m_rise[c] = 1'b1;
                            else         m_fall[c] = 1'b1;
                        end
                    end else begin
                        m_cnt[c] = 0;
                    end
                    if (!nout[c]) begin
                        m_lc[c] = 0;
                        m_held[c] = 1'b0;
                    end else if (m_out[c] && m_lc[c] < A_LONG) begin
                        m_lc[c] = m_lc[c] + 1;
                        if (m_lc[c] == A_LONG) begin
                            m_held[c] = 1'b1;
                            m_lp[c]   = 1'b1;
                        end
                    end
                end
            end
            m_out = nout;
            m_s2  = m_s1;
            m_s1  = din;
            m_any = |(m_rise | m_fall);
        end
        exp_q.push_back({m_out, m_rise, m_fall, m_held, m_lp, m_any});
    endtask

    task automatic step(input logic r, input logic t);
        reset = r;
        tick  = t;
        model_edge(r, t, in_a);
        @(posedge clock);
        #1;
        obs_q.push_back({out_a, rise_a, fall_a, held_a, lp_a, any_a});
    endtask

    task automatic tick_period();
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        logic [40:0] e, o;
        int n;
        in_a = 8'hFF;
        in_b = 8'h00;
        do_reset();
        checks++;
        if ({out_a, rise_a, fall_a, held_a, lp_a, any_a} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state_a: got %h expected 0", {out_a, rise_a, fall_a, held_a, lp_a, any_a});
        end
        checks++;
        if ({out_b, rise_b, fall_b, held_b, lp_b, any_b} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state_b: got %h expected 0", {out_b, rise_b, fall_b, held_b, lp_b, any_b});
        end
        n = 0;
        while (rise_a === 8'h00 && n < 40) begin
            tick_period();
            n++;
        end
        checks++;
        if (n != 16 || rise_a !== 8'hFF || any_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_rise: ticks %0d rise %h any %b, expected 16 ticks rise ff any 1", n, rise_a, any_a);
        end
        step(1'b0, 1'b0);
        checks++;
        if (rise_a !== 8'h00 || out_a !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rise_width: rise %h out %h, expected 00 ff", rise_a, out_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_model: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_bounce();
        logic [40:0] e, o;
        int n;
        in_a = 8'h00;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            in_a[0] = ((k / 3) % 2 == 0);
            tick_period();
            checks++;
            if (out_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_hold: tick %0d out0 %b expected 0", k, out_a[0]);
            end
        end
        in_a[0] = 1'b1;
        n = 0;
        while (out_a[0] !== 1'b1 && n < 40) begin
            tick_period();
            n++;
        end
        checks++;
        if (n != 16 || rise_a !== 8'h01) begin
            errors++;
            $display("FAIL bounce_settle: ticks %0d rise %h, expected 16 ticks rise 01", n, rise_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bounce_model: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_tick_high();
        logic [40:0] e, o;
        in_b = 8'h00;
        do_reset();
        in_b[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (k < 6) begin
                if (out_b !== 8'h00 || rise_b !== 8'h00) begin
                    errors++;
                    $display("FAIL tick_high_early: clk %0d out %h rise %h expected 00 00", k, out_b, rise_b);
                end
            end else if (k == 6) begin
                if (out_b !== 8'h04 || rise_b !== 8'h04 || any_b !== 1'b1) begin
                    errors++;
                    $display("FAIL tick_high_edge: out %h rise %h any %b expected 04 04 1", out_b, rise_b, any_b);
                end
            end else begin
                if (out_b !== 8'h04 || rise_b !== 8'h00 || any_b !== 1'b0) begin
                    errors++;
                    $display("FAIL tick_high_width: out %h rise %h any %b expected 04 00 0", out_b, rise_b, any_b);
                end
            end
        end
        checks++;
        if (held_b !== 8'h00 || lp_b !== 8'h00) begin
            errors++;
            $display("FAIL long_disabled: held %h lp %h expected 00 00", held_b, lp_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL tick_high_model: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_long_press();
        logic [40:0] e, o;
        int n;
        in_a = 8'h00;
        do_reset();
        in_a = 8'h08;
        n = 0;
        while (out_a[3] !== 1'b1 && n < 40) begin tick_period(); n++; end
        checks++;
        if (n != 16) begin errors++; $display("FAIL long_out_rise: ticks %0d expected 16", n); end
        n = 0;
        while (lp_a[3] !== 1'b1 && n < 20) begin tick_period(); n++; end
        checks++;
        if (n != 5 || held_a !== 8'h08 || lp_a !== 8'h08) begin
            errors++;
            $display("FAIL long_pulse: ticks %0d held %h lp %h expected 5 08 08", n, held_a, lp_a);
        end
        step(1'b0, 1'b0);
        checks++;
        if (lp_a !== 8'h00 || held_a !== 8'h08) begin
            errors++;
            $display("FAIL long_pulse_width: lp %h held %h expected 00 08", lp_a, held_a);
        end
        repeat (10) tick_period();
        checks++;
        if (held_a !== 8'h08) begin errors++; $display("FAIL long_held_stays: held %h expected 08", held_a); end
        in_a = 8'h00;
        n = 0;
        while (out_a[3] !== 1'b0 && n < 40) begin tick_period(); n++; end
        checks++;
        if (n != 16 || held_a !== 8'h00 || fall_a !== 8'h08 || lp_a !== 8'h00) begin
            errors++;
            $display("FAIL long_release: ticks %0d held %h fall %h lp %h expected 16 00 08 00", n, held_a, fall_a, lp_a);
        end
        step(1'b0, 1'b0);
        checks++;
        if (fall_a !== 8'h00) begin errors++; $display("FAIL long_fall_width: fall %h expected 00", fall_a); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL long_model: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [40:0] e, o;
        int n;
        in_a = 8'hFF;
        do_reset();
        repeat (10) tick_period();
        step(1'b1, 1'b1);
        checks++;
        if (out_a !== 8'h00 || rise_a !== 8'h00 || fall_a !== 8'h00 || any_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: out %h rise %h fall %h any %b expected 00 00 00 0", out_a, rise_a, fall_a, any_a);
        end
        n = 0;
        while (rise_a === 8'h00 && n < 40) begin tick_period(); n++; end
        checks++;
        if (n != 16 || rise_a !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_restart: ticks %0d rise %h expected 16 ff", n, rise_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_model: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_simultaneous();
        logic [40:0] e, o;
        in_a = 8'h00;
        do_reset();
        in_a = 8'h40;
        repeat (16) tick_period();
        checks++;
        if (out_a !== 8'h40) begin errors++; $display("FAIL simul_setup: out %h expected 40", out_a); end
        in_a = 8'h02;
        repeat (15) tick_period();
        checks++;
        if (rise_a !== 8'h00 || fall_a !== 8'h00 || out_a !== 8'h40) begin
            errors++;
            $display("FAIL simul_early: rise %h fall %h out %h expected 00 00 40", rise_a, fall_a, out_a);
        end
        tick_period();
        checks++;
        if (rise_a !== 8'h02 || fall_a !== 8'h40 || any_a !== 1'b1 || out_a !== 8'h02) begin
            errors++;
            $display("FAIL simul_edge: rise %h fall %h any %b out %h expected 02 40 1 02", rise_a, fall_a, any_a, out_a);
        end
        step(1'b0, 1'b0);
        checks++;
        if (rise_a !== 8'h00 || fall_a !== 8'h00 || any_a !== 1'b0) begin
            errors++;
            $display("FAIL simul_width: rise %h fall %h any %b expected 00 00 0", rise_a, fall_a, any_a);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL simul_model: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        in_a  = 8'h00;
        in_b  = 8'h00;
        test_reset();
        test_bounce();
        test_tick_high();
        test_long_press();
        test_reset_mid_count();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
